mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 SHALL have parameter REGADDR, default 5, register-file index width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port valid_in  input  1  MEM-stage instruction valid.
REQ-006 SHALL have port stall  input  1  hold MEM/WB register contents.
REQ-007 SHALL have port flush  input  1  invalidate MEM/WB register.
REQ-008 SHALL have port RegWrite_in  input  1  instruction writes a register.
REQ-009 SHALL have port MemtoReg_in  input  1  1 selects load data, 0 selects ALU result.
REQ-010 SHALL have port LoadType  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 treated as LW.
REQ-011 SHALL have port ALUResult  input  WIDTH  ALU result and memory byte address.
REQ-012 SHALL have port RD  input  WIDTH  data-memory read word (word-aligned).
REQ-013 SHALL have port WriteReg_in  input  REGADDR  destination register.
REQ-014 SHALL have port valid_out  output  1  WB instruction valid.
REQ-015 SHALL have port RegWrite_out  output  1  register-file write enable.
REQ-016 SHALL have port WriteReg_out  output  REGADDR  register-file write index.
REQ-017 SHALL have port WBData  output  WIDTH  register-file write data.
REQ-018 SHALL have port misalign_err  output  1  registered load misalignment flag.
REQ-019 SHALL have port retired  output  32  retired-instruction count.

Function
REQ-020 SHALL capture all *_in, LoadType, ALUResult, RD into MEM/WB register on rising edge when stall=0; one-cycle latency to outputs.
REQ-021 SHALL, with stall=1 and flush=0, hold all register contents and keep retired unchanged.
REQ-022 SHALL, with flush=1, clear stored valid on next edge regardless of stall (flush beats stall).
REQ-023 SHALL compute WBData from registered fields: MemtoReg=0 -> ALUResult; MemtoReg=1 -> extracted load data.
REQ-024 SHALL extract byte RD[8*a+7:8*a] for LB/LBU and halfword RD[16*h+15:16*h] for LH/LHU, a=ALUResult[1:0], h=ALUResult[1]; LB/LH sign-extend, LBU/LHU zero-extend to WIDTH.
REQ-025 SHALL assert misalign_err when valid, MemtoReg=1, and (LW with ALUResult[1:0]!=0, or LH/LHU with ALUResult[0]=1).
REQ-026 SHALL drive RegWrite_out = valid AND RegWrite AND (WriteReg!=0) AND NOT misalign_err.
REQ-027 SHALL increment retired by 1 on each rising edge where valid_out=1, stall=0, misalign_err=0; wraps from 0xFFFFFFFF to 0.
REQ-028 SHALL, on simultaneous stall=1 and flush=1, invalidate and not increment retired for the flushed cycle's edge.

Reset
REQ-029 SHALL, while rst=0, asynchronously force valid_out=0, RegWrite_out=0, WriteReg_out=0, WBData=0, misalign_err=0, retired=0.
REQ-030 SHALL, on rst deassertion mid-stream, accept the first valid_in only on the first rising edge with rst=1.

Configuration
REQ-031 SHALL use macro WB_SUBWORD_LOAD_EN: defined -> REQ-024 and LH/LHU/LB/LBU misalignment checks active.
REQ-032 SHALL, with WB_SUBWORD_LOAD_EN undefined, treat all LoadType as LW (load data = RD) and check only word alignment.

Verification
REQ-033 SHALL cover LW: ALUResult=0x100, RD=0xDEADBEEF, MemtoReg=1, WriteReg=8 -> next cycle WBData=0xDEADBEEF, RegWrite_out=1, retired+1.
REQ-034 SHALL cover LB/LBU: RD=0x80FF7F01, ALUResult=0x103 -> LB WBData=0xFFFFFF80, LBU WBData=0x00000080.
REQ-035 SHALL cover misalign: LH ALUResult=0x101 -> misalign_err=1, RegWrite_out=0, retired unchanged.
REQ-036 SHALL cover $0: ALU op, WriteReg=0, ALUResult=0x5 -> RegWrite_out=0, WBData=0x5, retired+1.
REQ-037 SHALL cover stall 3 cycles then flush with stall=1 -> outputs held 3 cycles, then valid_out=0, retired unchanged.
REQ-038 SHALL cover rst=0 asserted between edges with valid_out=1 -> all outputs 0 immediately, retired=0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register. It captures the MEM-stage
// instruction, extracts load data from the aligned read word, gates the
// register-file write and counts retired instructions.
//
// Optional feature macro: WB_SUBWORD_LOAD_EN
//   defined   -> LH/LHU/LB/LBU lane extraction with sign/zero extension, and
//                halfword/byte alignment rules.
//   undefined -> every load is treated as LW (load data = RD); only word
//                alignment is checked.
//
// LoadType encoding: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 behave as LW.
// The byte/halfword lane logic assumes WIDTH >= 32 (RD is one aligned word).

module mem_wb_stage #(
  parameter int WIDTH   = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic               stall,
  input  logic               flush,
  input  logic               RegWrite_in,
  input  logic               MemtoReg_in,
  input  logic [2:0]         LoadType,
  input  logic [WIDTH-1:0]   ALUResult,
  input  logic [WIDTH-1:0]   RD,
  input  logic [REGADDR-1:0] WriteReg_in,
  output logic               valid_out,
  output logic               RegWrite_out,
  output logic [REGADDR-1:0] WriteReg_out,
  output logic [WIDTH-1:0]   WBData,
  output logic               misalign_err,
  output logic [31:0]        retired
);

`ifdef WB_SUBWORD_LOAD_EN
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;
`endif

  logic               valid_q,    valid_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic [2:0]         loadtype_q, loadtype_d;
  logic [WIDTH-1:0]   alu_q,      alu_d;
  logic [WIDTH-1:0]   rd_q,       rd_d;
  logic [REGADDR-1:0] wreg_q,     wreg_d;
  logic               misalign_q, misalign_d;
  logic [31:0]        retired_q,  retired_d;

  logic               addr_bad;
  logic               retire_now;
  logic [WIDTH-1:0]   load_data;

  // Alignment check of the incoming MEM-stage access; the flag is captured
  // together with the instruction so the WB side sees a registered value.
  always_comb begin
    addr_bad = 1'b0;
`ifdef WB_SUBWORD_LOAD_EN
    case (LoadType)
      LT_LH, LT_LHU: addr_bad = ALUResult[0];
      LT_LB, LT_LBU: addr_bad = 1'b0;
      default:       addr_bad = |ALUResult[1:0];
    endcase
`else
    addr_bad = |ALUResult[1:0];
`endif
  end

  // An instruction in WB retires on an advancing edge unless it faulted.
  assign retire_now = valid_q & ~stall & ~misalign_q;

  // Next-state of the MEM/WB register: capture when not stalled, flush wins.
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    loadtype_d = loadtype_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    wreg_d     = wreg_q;
    misalign_d = misalign_q;
    if (!stall) begin
      valid_d    = valid_in;
      regwrite_d = RegWrite_in;
      memtoreg_d = MemtoReg_in;
      loadtype_d = LoadType;
      alu_d      = ALUResult;
      rd_d       = RD;
      wreg_d     = WriteReg_in;
      misalign_d = valid_in & MemtoReg_in & addr_bad;
    end
    if (flush) begin
      valid_d    = 1'b0;
      misalign_d = 1'b0;
    end
    retired_d = retired_q + {31'd0, retire_now};
  end

  // MEM/WB register and retired counter, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      loadtype_q <= 3'd0;
      alu_q      <= '0;
      rd_q       <= '0;
      wreg_q     <= '0;
      misalign_q <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      loadtype_q <= loadtype_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      wreg_q     <= wreg_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Lane selection from the aligned read word, then sign/zero extension.
  always_comb begin
    case (alu_q[1:0])
      2'd0:    ld_byte = rd_q[7:0];
      2'd1:    ld_byte = rd_q[15:8];
      2'd2:    ld_byte = rd_q[23:16];
      default: ld_byte = rd_q[31:24];
    endcase
    ld_half = alu_q[1] ? rd_q[31:16] : rd_q[15:0];
    case (loadtype_q)
      LT_LH:   load_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      LT_LHU:  load_data = {{(WIDTH-16){1'b0}}, ld_half};
      LT_LB:   load_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      LT_LBU:  load_data = {{(WIDTH-8){1'b0}}, ld_byte};
      default: load_data = rd_q;
    endcase
  end
`else
  logic unused_loadtype;

  // Word-only loads: the read word is the load data as-is.
  always_comb begin
    load_data = rd_q;
  end

  assign unused_loadtype = ^loadtype_q;
`endif

  assign valid_out    = valid_q;
  assign WriteReg_out = wreg_q;
  assign misalign_err = misalign_q;
  assign WBData       = memtoreg_q ? load_data : alu_q;
  assign RegWrite_out = valid_q & regwrite_q & (|wreg_q) & ~misalign_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: vector table run through a scoreboard queue, followed by
// hand-written stall/flush and asynchronous reset sequences.

module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        stall;
  logic        flush;
  logic        RegWrite_in;
  logic        MemtoReg_in;
  logic [2:0]  LoadType;
  logic [31:0] ALUResult;
  logic [31:0] RD;
  logic [4:0]  WriteReg_in;
  logic        valid_out;
  logic        RegWrite_out;
  logic [4:0]  WriteReg_out;
  logic [31:0] WBData;
  logic        misalign_err;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ret;

  mem_wb_stage #(.WIDTH(32), .REGADDR(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .stall        (stall),
    .flush        (flush),
    .RegWrite_in  (RegWrite_in),
    .MemtoReg_in  (MemtoReg_in),
    .LoadType     (LoadType),
    .ALUResult    (ALUResult),
    .RD           (RD),
    .WriteReg_in  (WriteReg_in),
    .valid_out    (valid_out),
    .RegWrite_out (RegWrite_out),
    .WriteReg_out (WriteReg_out),
    .WBData       (WBData),
    .misalign_err (misalign_err),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wreg;
    logic        e_rw;
    logic [31:0] e_wb;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wb;
    logic        mis;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];

  function automatic vec_t mk(logic v, logic rw, logic m2r, logic [2:0] lt,
                              logic [31:0] alu, logic [31:0] rd, logic [4:0] wreg,
                              logic e_rw, logic [31:0] e_wb, logic e_mis);
    vec_t t;
    t.v = v; t.rw = rw; t.m2r = m2r; t.lt = lt; t.alu = alu; t.rd = rd;
    t.wreg = wreg; t.e_rw = e_rw; t.e_wb = e_wb; t.e_mis = e_mis;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] wreg);
    valid_in    = v;
    RegWrite_in = rw;
    MemtoReg_in = m2r;
    LoadType    = lt;
    ALUResult   = alu;
    RD          = rd;
    WriteReg_in = wreg;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid_out"},    {31'd0, valid_out},    32'd0);
    chk({tag, " RegWrite_out"}, {31'd0, RegWrite_out}, 32'd0);
    chk({tag, " WriteReg_out"}, {27'd0, WriteReg_out}, 32'd0);
    chk({tag, " WBData"},       WBData,                32'd0);
    chk({tag, " misalign_err"}, {31'd0, misalign_err}, 32'd0);
    chk({tag, " retired"},      retired,               32'd0);
  endtask

  initial begin
    exp_t e;

    // LW at 0x100, ALU op to $0, and loads whose result depends on the build.
    vecs[0]  = mk(1, 1, 1, 3'd0, 32'h100, 32'hDEADBEEF, 5'd8,  1, 32'hDEADBEEF, 0);
`ifdef WB_SUBWORD_LOAD_EN
    vecs[1]  = mk(1, 1, 1, 3'd3, 32'h103, 32'h80FF7F01, 5'd9,  1, 32'hFFFFFF80, 0);
    vecs[2]  = mk(1, 1, 1, 3'd4, 32'h103, 32'h80FF7F01, 5'd9,  1, 32'h00000080, 0);
    vecs[3]  = mk(1, 1, 1, 3'd1, 32'h101, 32'h80FF7F01, 5'd10, 0, 32'h00007F01, 1);
    vecs[5]  = mk(1, 1, 1, 3'd1, 32'h102, 32'h80FF7F01, 5'd11, 1, 32'hFFFF80FF, 0);
    vecs[6]  = mk(1, 1, 1, 3'd2, 32'h102, 32'h80FF7F01, 5'd11, 1, 32'h000080FF, 0);
    vecs[7]  = mk(1, 1, 1, 3'd3, 32'h101, 32'h80FF7F01, 5'd12, 1, 32'h0000007F, 0);
`else
    vecs[1]  = mk(1, 1, 1, 3'd3, 32'h103, 32'h80FF7F01, 5'd9,  0, 32'h80FF7F01, 1);
    vecs[2]  = mk(1, 1, 1, 3'd4, 32'h103, 32'h80FF7F01, 5'd9,  0, 32'h80FF7F01, 1);
    vecs[3]  = mk(1, 1, 1, 3'd1, 32'h101, 32'h80FF7F01, 5'd10, 0, 32'h80FF7F01, 1);
    vecs[5]  = mk(1, 1, 1, 3'd1, 32'h102, 32'h80FF7F01, 5'd11, 0, 32'h80FF7F01, 1);
    vecs[6]  = mk(1, 1, 1, 3'd2, 32'h102, 32'h80FF7F01, 5'd11, 0, 32'h80FF7F01, 1);
    vecs[7]  = mk(1, 1, 1, 3'd3, 32'h101, 32'h80FF7F01, 5'd12, 0, 32'h80FF7F01, 1);
`endif
    vecs[4]  = mk(1, 1, 0, 3'd0, 32'h5,   32'h12345678, 5'd0,  0, 32'h00000005, 0);
    vecs[8]  = mk(0, 1, 1, 3'd0, 32'h101, 32'hCAFEF00D, 5'd13, 0, 32'hCAFEF00D, 0);
    vecs[9]  = mk(1, 1, 1, 3'd7, 32'h200, 32'h11223344, 5'd31, 1, 32'h11223344, 0);
    vecs[10] = mk(1, 1, 1, 3'd5, 32'h201, 32'h55667788, 5'd14, 0, 32'h55667788, 1);
    vecs[11] = mk(1, 1, 0, 3'd0, 32'h3,   32'h0,        5'd7,  1, 32'h00000003, 0);

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    #1 rst = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_ret = 32'd0;

    // Table vectors, one per cycle, expectations queued at drive time.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].alu, vecs[i].rd, vecs[i].wreg);
      e.valid = vecs[i].v; e.rw = vecs[i].e_rw; e.wreg = vecs[i].wreg;
      e.wb = vecs[i].e_wb; e.mis = vecs[i].e_mis;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard empty at vec %0d", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d valid_out", i),    {31'd0, valid_out},    {31'd0, e.valid});
        chk($sformatf("v%0d RegWrite_out", i), {31'd0, RegWrite_out}, {31'd0, e.rw});
        chk($sformatf("v%0d WriteReg_out", i), {27'd0, WriteReg_out}, {27'd0, e.wreg});
        chk($sformatf("v%0d WBData", i),       WBData,                e.wb);
        chk($sformatf("v%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, e.mis});
        chk($sformatf("v%0d retired", i),      retired,               exp_ret);
        if (e.valid && !e.mis) exp_ret = exp_ret + 32'd1;
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("table tail retired", retired, exp_ret);
    chk("table tail valid_out", {31'd0, valid_out}, 32'd0);

    // Stall three cycles holding a LW, then flush while still stalled.
    @(negedge clk);
    drive(1, 1, 1, 3'd0, 32'h100, 32'hDEADBEEF, 5'd8);
    @(posedge clk); #1;
    chk("stall pre valid_out", {31'd0, valid_out}, 32'd1);
    chk("stall pre WBData", WBData, 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1, 1, 0, 3'd0, 32'h5, 32'h0, 5'd3);
      @(posedge clk); #1;
      chk($sformatf("stall%0d valid_out", k),    {31'd0, valid_out},    32'd1);
      chk($sformatf("stall%0d RegWrite_out", k), {31'd0, RegWrite_out}, 32'd1);
      chk($sformatf("stall%0d WriteReg_out", k), {27'd0, WriteReg_out}, 32'd8);
      chk($sformatf("stall%0d WBData", k),       WBData,                32'hDEADBEEF);
      chk($sformatf("stall%0d retired", k),      retired,               exp_ret);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk("stallflush valid_out", {31'd0, valid_out}, 32'd0);
    chk("stallflush RegWrite_out", {31'd0, RegWrite_out}, 32'd0);
    chk("stallflush retired", retired, exp_ret);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("postflush retired", retired, exp_ret);

    // Flush without stall: incoming is dropped, the WB instruction retires.
    @(negedge clk);
    drive(1, 1, 0, 3'd0, 32'h77, 32'h0, 5'd4);
    @(posedge clk); #1;
    chk("flush0 pre valid_out", {31'd0, valid_out}, 32'd1);
    chk("flush0 pre WBData", WBData, 32'h77);
    @(negedge clk);
    flush = 1'b1;
    drive(1, 1, 0, 3'd0, 32'h88, 32'h0, 5'd5);
    @(posedge clk); #1;
    exp_ret = exp_ret + 32'd1;
    chk("flush0 valid_out", {31'd0, valid_out}, 32'd0);
    chk("flush0 retired", retired, exp_ret);
    @(negedge clk);
    flush = 1'b0;

    // Asynchronous reset between edges, then release mid-stream.
    drive(1, 1, 1, 3'd0, 32'h100, 32'hDEADBEEF, 5'd8);
    @(posedge clk); #1;
    chk("areset pre valid_out", {31'd0, valid_out}, 32'd1);
    chk("areset pre retired", retired, exp_ret);
    #2 rst = 1'b0;
    #1 chk_all_zero("areset");
    @(posedge clk); #1;
    chk("areset held valid_out", {31'd0, valid_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("release valid_out", {31'd0, valid_out}, 32'd1);
    chk("release WBData", WBData, 32'hDEADBEEF);
    chk("release retired", retired, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    chk("release retired+1", retired, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
